// File: rtl/fluorescence_uart_reporter.sv
// fluorescence_uart_reporter
// Captures integration results into a one-deep pending slot and sends each one
// as a 15-byte checksummed packet over a UART 8N1 line:
//   A5, seq, result[31:0] BE, add_count[31:0] BE, subtract_count[31:0] BE, checksum
// The checksum is the sum of bytes 1..13 modulo 256. The sync byte is not included.
// Results that arrive while the slot is occupied are dropped.
// A saturating overrun counter records how many were dropped.
module fluorescence_uart_reporter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock_50_mhz,
    input  logic        reset,
    input  logic        result_valid,
    input  logic [31:0] result,
    input  logic [31:0] add_count,
    input  logic [31:0] subtract_count,
    output logic        uart_tx,
    output logic        busy,
    output logic [7:0]  overrun_count
);
    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;
    localparam logic [3:0]    LAST_BYTE = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [3:0]    byte_idx_q;
    logic          pend_full_q;
    logic [95:0]   pend_data_q;
    logic [95:0]   snap_q;
    logic [7:0]    seq_q;
    logic [7:0]    overrun_q;
    logic          tx_q;
    logic          busy_q;

    logic          bit_end_s;
    logic          pkt_end_s;
    logic          drain_s;
    logic          accept_s;
    logic          overrun_s;
    logic          pend_full_d;
    logic          idle_d;
    logic          busy_d;
    logic [95:0]   in_data_s;
    logic [119:0]  frame_s;
    logic [6:0]    byte_base_s;
    logic [7:0]    cur_byte_s;
    logic [2:0]    next_bit_s;

    // Modulo-256 sum of the sequence byte and the twelve payload bytes.
    function automatic logic [7:0] frame_checksum(input logic [7:0] seq, input logic [95:0] data);
        logic [7:0] sum;
        sum = seq;
        for (int i = 0; i < 12; i++) begin
            sum = sum + data[i*8 +: 8];
        end
        return sum;
    endfunction

    // Slot arbitration, current frame byte selection and next-cycle busy.
    always_comb begin
        in_data_s = {result, add_count, subtract_count};
        bit_end_s = (baud_q == BAUD_LAST);
        pkt_end_s = (state_q == ST_STOP) && bit_end_s && (byte_idx_q == LAST_BYTE);
        // The slot is drained on the edge where a packet is started from it.
        if ((state_q == ST_IDLE) || pkt_end_s) begin
            drain_s = pend_full_q;
        end else begin
            drain_s = 1'b0;
        end
        accept_s  = result_valid && (!pend_full_q || drain_s);
        overrun_s = result_valid && pend_full_q && !drain_s;
        if (accept_s) begin
            pend_full_d = 1'b1;
        end else if (drain_s) begin
            pend_full_d = 1'b0;
        end else begin
            pend_full_d = pend_full_q;
        end
        idle_d = ((state_q == ST_IDLE) || pkt_end_s) && !pend_full_q;
        busy_d = !idle_d || pend_full_d;
        // seq_q is stable for the whole packet, so it is used directly as the snapshot seq.
        frame_s     = {SYNC_BYTE, seq_q, snap_q, frame_checksum(seq_q, snap_q)};
        byte_base_s = 7'd119 - {byte_idx_q, 3'b000};
        cur_byte_s  = frame_s[byte_base_s -: 8];
        next_bit_s  = bit_idx_q + 3'd1;
    end

    // Pending slot, overrun counter and UART transmit FSM with registered line and busy.
    always_ff @(posedge clock_50_mhz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 4'd0;
            pend_full_q <= 1'b0;
            pend_data_q <= 96'd0;
            snap_q      <= 96'd0;
            seq_q       <= 8'd0;
            overrun_q   <= 8'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            pend_full_q <= pend_full_d;
            busy_q      <= busy_d;
            if (accept_s) begin
                pend_data_q <= in_data_s;
            end
            if (overrun_s && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pend_full_q) begin
                        state_q    <= ST_START;
                        snap_q     <= pend_data_q;
                        byte_idx_q <= 4'd0;
                        baud_q     <= '0;
                        tx_q       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_q   <= ST_DATA;
                        baud_q    <= '0;
                        bit_idx_q <= 3'd0;
                        tx_q      <= cur_byte_s[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= next_bit_s;
                            tx_q      <= cur_byte_s[next_bit_s];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_q <= '0;
                        if (byte_idx_q == LAST_BYTE) begin
                            seq_q <= seq_q + 8'd1;
                            if (pend_full_q) begin
                                // Back-to-back packet: no idle bit between packets.
                                state_q    <= ST_START;
                                snap_q     <= pend_data_q;
                                byte_idx_q <= 4'd0;
                                tx_q       <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            state_q    <= ST_START;
                            byte_idx_q <= byte_idx_q + 4'd1;
                            tx_q       <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx       = tx_q;
    assign busy          = busy_q;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_fluorescence_uart_reporter.sv
// Testbench for fluorescence_uart_reporter.
// A packet-level reference model predicts which results are sent, and when.
// It also predicts the seq value, the busy output and the overrun count.
// A UART decoder pops the predicted packets and checks them byte by byte.
module tb_fluorescence_uart_reporter;
    localparam int CPB      = 2;
    localparam int PKT_CYC  = 150 * CPB;
    localparam int BYTE_CYC = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        result_valid = 1'b0;
    logic [31:0] result = 32'd0;
    logic [31:0] add_count = 32'd0;
    logic [31:0] subtract_count = 32'd0;
    logic        uart_tx;
    logic        busy;
    logic [7:0]  overrun_count;

    always #5 clk = ~clk;

    fluorescence_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clock_50_mhz   (clk),
        .reset          (reset),
        .result_valid   (result_valid),
        .result         (result),
        .add_count      (add_count),
        .subtract_count (subtract_count),
        .uart_tx        (uart_tx),
        .busy           (busy),
        .overrun_count  (overrun_count)
    );

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [119:0] pkt;
        int unsigned  start;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state (packet-level view)
    bit          m_inflight = 1'b0;
    bit          m_pend = 1'b0;
    int unsigned m_end = 0;
    logic [7:0]  m_seq = 8'd0;
    logic [7:0]  m_ovr = 8'd0;
    logic [31:0] m_r, m_a, m_s;

    // Monitor status visible to the stimulus
    bit          mon_idle = 1'b1;
    bit          saw_wrap = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [119:0] make_packet(input logic [7:0] seq, input logic [31:0] r,
                                                 input logic [31:0] a, input logic [31:0] s);
        int unsigned w [3];
        int unsigned b [15];
        int unsigned sum;
        logic [119:0] p;
        w[0] = r; w[1] = a; w[2] = s;
        b[0] = 32'hA5;
        b[1] = 32'(seq);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++)
                b[2 + 4*i + j] = (w[i] >> (8 * (3 - j))) & 32'hFF;
        sum = 0;
        for (int k = 1; k <= 13; k++) sum += b[k];
        b[14] = sum % 256;
        p = '0;
        for (int k = 0; k < 15; k++) p = (p << 8) | 120'(b[k]);
        return p;
    endfunction

    // Reference model: one step per rising edge
    initial begin : model
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_inflight = 1'b0;
                m_pend     = 1'b0;
                m_seq      = 8'd0;
                m_ovr      = 8'd0;
            end else begin
                if (m_inflight && cyc == m_end) begin
                    m_inflight = 1'b0;
                    m_seq      = m_seq + 8'd1;
                end
                if (m_pend && !m_inflight) begin
                    m_inflight = 1'b1;
                    m_end      = cyc + PKT_CYC;
                    e.pkt      = make_packet(m_seq, m_r, m_a, m_s);
                    e.start    = cyc;
                    exp_q.push_back(e);
                    m_pend     = 1'b0;
                end
                if (result_valid) begin
                    if (!m_pend) begin
                        m_pend = 1'b1;
                        m_r = result; m_a = add_count; m_s = subtract_count;
                    end else if (m_ovr != 8'd255) begin
                        m_ovr = m_ovr + 8'd1;
                    end
                end
            end
        end
    end

    // Monitor: output checks and UART decode on falling edges
    initial begin : monitor
        bit          hunting = 1'b1;
        bit          have = 1'b0;
        int          cnt = 0;
        int          bi = 0;
        int unsigned bstart = 0;
        logic [7:0]  sh = 8'd0;
        logic [7:0]  last_seq = 8'd0;
        exp_t        cur;
        forever begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(m_inflight | m_pend));
            chk("overrun_count", 32'(overrun_count), 32'(m_ovr));
            if (!m_inflight) chk("tx_idle_high", 32'(uart_tx), 32'd1);
            if (reset) begin
                exp_q.delete();
                hunting = 1'b1; have = 1'b0; bi = 0;
            end else if (hunting) begin
                if (uart_tx == 1'b0) begin
                    hunting = 1'b0; cnt = 0; bstart = cyc;
                    if (bi == 0) begin
                        if (exp_q.size() == 0) begin
                            checks++; failures++; have = 1'b0;
                            $display("FAIL unexpected_packet: start bit at cycle %0d with none expected", cyc);
                        end else begin
                            cur = exp_q.pop_front(); have = 1'b1;
                            chk("pkt_start_cycle", bstart, cur.start);
                        end
                    end else if (have) begin
                        chk("byte_start_cycle", bstart, cur.start + 32'(bi * BYTE_CYC));
                    end
                end
            end else begin
                cnt++;
                if ((cnt % CPB) == (CPB / 2) && (cnt / CPB) >= 1 && (cnt / CPB) <= 8)
                    sh[(cnt / CPB) - 1] = uart_tx;
                if (cnt == 9 * CPB + CPB / 2) begin
                    chk("stop_bit", 32'(uart_tx), 32'd1);
                    if (have) begin
                        chk($sformatf("pkt_byte%0d", bi), 32'(sh), 32'(8'(cur.pkt >> (8 * (14 - bi)))));
                        if (bi == 1) begin
                            if (last_seq == 8'd255 && sh == 8'd0) saw_wrap = 1'b1;
                            last_seq = sh;
                        end
                    end
                    bi = (bi == 14) ? 0 : bi + 1;
                    hunting = 1'b1;
                end
            end
            mon_idle = hunting && (bi == 0);
        end
    end

    task automatic pulse(input logic [31:0] r, input logic [31:0] a, input logic [31:0] s);
        result = r; add_count = a; subtract_count = s; result_valid = 1'b1;
        @(posedge clk); #1;
        result_valid = 1'b0;
    endtask

    task automatic pulse_rand();
        pulse($urandom, $urandom, $urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((m_inflight || m_pend || exp_q.size() != 0 || !mon_idle) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        idle(4);
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL wait_quiet: still busy after %0d cycles (required done within budget)", n);
        end
    endtask

    initial begin : stimulus
        int n;
        // Reset and idle line
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(1000);

        // Single packet with a negative result
        pulse(32'hFFFF_FFFB, 32'd100, 32'd105);
        wait_quiet(PKT_CYC + 50);

        // Back-to-back: second result arrives mid-packet
        pulse_rand();
        idle(100);
        pulse_rand();
        wait_quiet(2 * PKT_CYC + 50);

        // Overrun: results 2 and 3 arrive during packet 1
        pulse_rand();
        idle(50);
        pulse_rand();
        idle(10);
        pulse_rand();
        wait_quiet(2 * PKT_CYC + 50);
        chk("overrun_one", 32'(overrun_count), 32'd1);

        // Saturate the overrun counter
        for (int i = 0; i < 400; i++) pulse_rand();
        wait_quiet(3 * PKT_CYC);
        chk("overrun_sat", 32'(overrun_count), 32'd255);

        // Reset during byte 5, with a result_valid coincident with reset
        pulse_rand();
        idle(5 * BYTE_CYC + 3);
        reset = 1'b1;
        result = $urandom; result_valid = 1'b1;
        @(posedge clk); #1;
        result_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("overrun_after_reset", 32'(overrun_count), 32'd0);
        idle(20);
        pulse_rand();
        wait_quiet(PKT_CYC + 50);

        // Same-edge drain: second valid on the edge the slot is loaded into the FSM
        pulse_rand();
        pulse_rand();
        wait_quiet(2 * PKT_CYC + 50);
        chk("overrun_same_edge", 32'(overrun_count), 32'd0);

        // Random results with random gaps
        for (int i = 0; i < 4; i++) begin
            pulse_rand();
            idle($urandom_range(0, 200));
        end
        wait_quiet(5 * PKT_CYC);

        // Continuous traffic until the sequence number wraps
        for (int i = 0; i < 252; i++) begin
            n = 0;
            while (m_pend && n < 2 * PKT_CYC) begin
                @(posedge clk); #1; n++;
            end
            pulse_rand();
        end
        wait_quiet(3 * PKT_CYC);
        chk("seq_wrap_seen", 32'(saw_wrap), 32'd1);
        chk("expected_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
